// File: rtl/rp_8bit_pkg.sv
// rp_8bit_pkg: shared rp_8bit core types, opcode patterns and helpers
package rp_8bit_pkg;
    localparam logic [15:0] LDS_STS_MSK  = 16'hFC0F;
    localparam logic [15:0] LDS_STS_PAT  = 16'h9000;
    localparam logic [15:0] JMP_CALL_MSK = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_PAT = 16'h940C;
    typedef enum logic {FW, SW} ifu_state_t;
    function automatic logic ins_is_two(input logic [15:0] ins);
        return ((ins & LDS_STS_MSK) == LDS_STS_PAT) || ((ins & JMP_CALL_MSK) == JMP_CALL_PAT);
    endfunction
endpackage

// File: rtl/rp_8bit_ifu.sv
// rp_8bit_ifu: fetches program words, assembles one/two-word instructions and
// hands them to decode, applying redirect and skip requests on the way.
module rp_8bit_ifu
    import rp_8bit_pkg::*;
#(
    parameter int PAW = 22,
    parameter logic [PAW-1:0] PC_RST = '0
) (
    input  logic           clk,
    input  logic           rst,
    output logic           pmem_req,
    output logic [PAW-1:0] pmem_adr,
    input  logic [15:0]    pmem_rdt,
    input  logic           pmem_ack,
    output logic           ifu_vld,
    input  logic           ifu_rdy,
    output logic [31:0]    ifu_ins,
    output logic           ifu_two,
    output logic [PAW-1:0] ifu_pc,
    input  logic           jmp_vld,
    input  logic [PAW-1:0] jmp_pc,
    input  logic           skp
);
    ifu_state_t state;
    logic run, pend, drop, skip;
    logic [PAW-1:0] pc, tgt;
    logic [15:0] ins_lo;
    logic free, ack, done, keep;
    assign pmem_adr = pc;
    // free: the output register is empty or leaves it this cycle (handshake or skip)
    always_comb begin
        free = !ifu_vld || skp || ifu_rdy;
        pmem_req = run && (pend || (free && !jmp_vld));
        ack = pmem_req && pmem_ack;
        done = ack && !drop && !jmp_vld && (state == SW || !ins_is_two(pmem_rdt));
        keep = done && !skip && !(skp && !ifu_vld);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FW;
            run     <= 1'b0;
            pend    <= 1'b0;
            drop    <= 1'b0;
            skip    <= 1'b0;
            pc      <= PC_RST;
            tgt     <= '0;
            ins_lo  <= '0;
            ifu_vld <= 1'b0;
            ifu_ins <= '0;
            ifu_two <= 1'b0;
            ifu_pc  <= '0;
        end else begin
            run  <= 1'b1;
            pend <= pmem_req && !pmem_ack;
            if (jmp_vld) begin
                state   <= FW;
                ins_lo  <= '0;
                skip    <= 1'b0;
                ifu_vld <= 1'b0;
                // a pending request must finish at its held address; its data is dropped
                if (pmem_req && !pmem_ack) begin
                    drop <= 1'b1;
                    tgt  <= jmp_pc;
                end else begin
                    drop <= 1'b0;
                    pc   <= jmp_pc;
                end
            end else begin
                if (ack && drop) begin
                    drop <= 1'b0;
                    pc   <= tgt;
                end else if (ack) begin
                    pc <= pc + PAW'(1);
                    if (state == FW && ins_is_two(pmem_rdt)) begin
                        state  <= SW;
                        ins_lo <= pmem_rdt;
                    end else begin
                        state  <= FW;
                        ins_lo <= '0;
                    end
                end
                if (done)
                    skip <= 1'b0;
                else if (skp && !ifu_vld)
                    skip <= 1'b1;
                if (keep) begin
                    ifu_vld <= 1'b1;
                    ifu_ins <= (state == SW) ? {pmem_rdt, ins_lo} : {16'h0000, pmem_rdt};
                    ifu_two <= state == SW;
                    ifu_pc  <= (state == SW) ? pc - PAW'(1) : pc;
                end else if (ifu_vld && free) begin
                    ifu_vld <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rp_8bit_ifu.sv
// tb_rp_8bit_ifu: directed checks of fetch, assembly, hold, skip, redirect and reset.
module tb_rp_8bit_ifu;
    localparam int PAW = 22;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pmem_req, pmem_ack, ifu_vld, ifu_two;
    logic [PAW-1:0] pmem_adr, ifu_pc;
    logic [15:0] pmem_rdt;
    logic [31:0] ifu_ins;
    logic ifu_rdy = 1'b1;
    logic jmp_vld = 1'b0;
    logic skp = 1'b0;
    logic late = 1'b0;
    logic [PAW-1:0] jmp_pc = '0;
    int sel = 0, waits = 0, cnt = 0, hs4 = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    rp_8bit_ifu #(.PAW(PAW), .PC_RST(22'd0)) dut (
        .clk(clk), .rst(rst), .pmem_req(pmem_req), .pmem_adr(pmem_adr),
        .pmem_rdt(pmem_rdt), .pmem_ack(pmem_ack), .ifu_vld(ifu_vld), .ifu_rdy(ifu_rdy),
        .ifu_ins(ifu_ins), .ifu_two(ifu_two), .ifu_pc(ifu_pc), .jmp_vld(jmp_vld),
        .jmp_pc(jmp_pc), .skp(skp)
    );

    function automatic logic [15:0] rd(input int s, input logic [PAW-1:0] a);
        if (s == 0) return 16'h0000;
        case (a)
            22'd0: return 16'h940C;
            22'd1: return 16'h1234;
            22'd2: return 16'h0001;
            22'd3: return 16'h0002;
            22'd4: return 16'h9200;
            22'd5: return 16'h5555;
            22'd8: return 16'h91C0;
            22'd9: return 16'h9999;
            default: return a[15:0];
        endcase
    endfunction

    assign pmem_rdt = rd(sel, pmem_adr);
    assign pmem_ack = (pmem_req && cnt == waits) || late;

    always @(posedge clk) begin
        cnt <= (pmem_req && !pmem_ack) ? cnt + 1 : 0;
        if (!rst && ifu_vld && ifu_rdy && !skp && !jmp_vld && ifu_pc == 22'd4) hs4 <= hs4 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!ifu_vld && n < 30);
        chk(tag, 64'(ifu_vld), 64'(1));
    endtask

    initial begin
        @(negedge clk); #1;
        chk("rst_req", 64'(pmem_req), 64'(0));
        chk("rst_adr", 64'(pmem_adr), 64'(0));
        chk("rst_vld", 64'(ifu_vld), 64'(0));
        chk("rst_ins", 64'(ifu_ins), 64'(0));
        chk("rst_two", 64'(ifu_two), 64'(0));
        chk("rst_pc", 64'(ifu_pc), 64'(0));
        @(negedge clk); rst = 1'b0; #1;
        chk("first_req_low", 64'(pmem_req), 64'(0));
        @(negedge clk); #1;
        chk("s1_req", 64'(pmem_req), 64'(1));
        chk("s1_adr0", 64'(pmem_adr), 64'(0));
        chk("s1_vld0", 64'(ifu_vld), 64'(0));
        @(negedge clk); #1;
        chk("s1_adr1", 64'(pmem_adr), 64'(1));
        chk("s1_vld_c2", 64'(ifu_vld), 64'(1));
        chk("s1_pc0", 64'(ifu_pc), 64'(0));
        @(negedge clk); #1;
        chk("s1_adr2", 64'(pmem_adr), 64'(2));
        chk("s1_vld_c3", 64'(ifu_vld), 64'(1));
        chk("s1_pc1", 64'(ifu_pc), 64'(1));
        @(negedge clk); #1;
        chk("s1_pc2", 64'(ifu_pc), 64'(2));
        chk("s1_ins", 64'(ifu_ins), 64'(0));
        // second program: jmp/call, sts, lds pairs
        @(negedge clk); sel = 1; rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; #1;
        chk("s2_req_low", 64'(pmem_req), 64'(0));
        @(negedge clk); #1;
        chk("s2_adr0", 64'(pmem_adr), 64'(0));
        @(negedge clk); #1;
        chk("s2_adr1", 64'(pmem_adr), 64'(1));
        chk("s2_vld_mid", 64'(ifu_vld), 64'(0));
        @(negedge clk); #1;
        chk("jmp_vld", 64'(ifu_vld), 64'(1));
        chk("jmp_ins", 64'(ifu_ins), 64'h1234940C);
        chk("jmp_two", 64'(ifu_two), 64'(1));
        chk("jmp_pc", 64'(ifu_pc), 64'(0));
        @(negedge clk); #1;
        chk("after_jmp_pc", 64'(ifu_pc), 64'(2));
        chk("after_jmp_ins", 64'(ifu_ins), 64'h00000001);
        chk("after_jmp_two", 64'(ifu_two), 64'(0));
        ifu_rdy = 1'b0; #1;
        chk("hold_req0", 64'(pmem_req), 64'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("hold_vld", 64'(ifu_vld), 64'(1));
            chk("hold_pc", 64'(ifu_pc), 64'(2));
            chk("hold_ins", 64'(ifu_ins), 64'h00000001);
            chk("hold_req", 64'(pmem_req), 64'(0));
        end
        @(negedge clk); ifu_rdy = 1'b1; #1;
        chk("resume_adr", 64'(pmem_adr), 64'(3));
        @(negedge clk); #1;
        chk("resume_pc", 64'(ifu_pc), 64'(3));
        @(negedge clk); #1;
        chk("sts_gap", 64'(ifu_vld), 64'(0));
        @(negedge clk); #1;
        chk("sts_pc", 64'(ifu_pc), 64'(4));
        chk("sts_ins", 64'(ifu_ins), 64'h55559200);
        skp = 1'b1; #1;
        chk("skp_full_req", 64'(pmem_req), 64'(1));
        @(negedge clk); skp = 1'b0; #1;
        chk("skp_full_next_pc", 64'(ifu_pc), 64'(6));
        chk("skp_full_vld", 64'(ifu_vld), 64'(1));
        chk("skp_no_hs4", 64'(hs4), 64'(0));
        @(negedge clk); #1;
        chk("pc7", 64'(ifu_pc), 64'(7));
        // two wait states from here; redirect while a request is pending
        waits = 2; #1;
        chk("w_req", 64'(pmem_req), 64'(1));
        chk("w_ack", 64'(pmem_ack), 64'(0));
        @(negedge clk); jmp_vld = 1'b1; jmp_pc = 22'h3FFFFF; #1;
        chk("redir_adr_held", 64'(pmem_adr), 64'(8));
        @(negedge clk); jmp_vld = 1'b0; #1;
        chk("redir_still_adr", 64'(pmem_adr), 64'(8));
        chk("redir_still_req", 64'(pmem_req), 64'(1));
        chk("redir_vld0", 64'(ifu_vld), 64'(0));
        @(negedge clk); #1;
        chk("redir_new_adr", 64'(pmem_adr), 64'h3FFFFF);
        wait_vld("redir_wait");
        chk("redir_pc", 64'(ifu_pc), 64'h3FFFFF);
        chk("redir_ins", 64'(ifu_ins), 64'h0000FFFF);
        wait_vld("wrap_wait");
        chk("wrap_pc", 64'(ifu_pc), 64'(0));
        chk("wrap_ins", 64'(ifu_ins), 64'h1234940C);
        // jmp and skp together: skp must be ignored
        jmp_vld = 1'b1; jmp_pc = 22'd8; skp = 1'b1; #1;
        chk("js_req0", 64'(pmem_req), 64'(0));
        @(negedge clk); jmp_vld = 1'b0; skp = 1'b0; #1;
        chk("js_adr", 64'(pmem_adr), 64'(8));
        chk("js_vld0", 64'(ifu_vld), 64'(0));
        wait_vld("js_wait");
        chk("js_pc", 64'(ifu_pc), 64'(8));
        chk("js_ins", 64'(ifu_ins), 64'h999991C0);
        chk("js_two", 64'(ifu_two), 64'(1));
        // skp with the output empty discards the lds at 8
        jmp_vld = 1'b1; jmp_pc = 22'd8; #1;
        @(negedge clk); jmp_vld = 1'b0; skp = 1'b1; #1;
        chk("skpe_req", 64'(pmem_req), 64'(1));
        chk("skpe_vld0", 64'(ifu_vld), 64'(0));
        @(negedge clk); skp = 1'b0; #1;
        wait_vld("skpe_wait");
        chk("skpe_pc", 64'(ifu_pc), 64'(10));
        chk("skpe_ins", 64'(ifu_ins), 64'h0000000A);
        // zero-wait redirect latency
        waits = 0; jmp_vld = 1'b1; jmp_pc = 22'd2; #1;
        chk("zr_req0", 64'(pmem_req), 64'(0));
        @(negedge clk); jmp_vld = 1'b0; #1;
        chk("zr_req", 64'(pmem_req), 64'(1));
        chk("zr_adr", 64'(pmem_adr), 64'(2));
        chk("zr_vld0", 64'(ifu_vld), 64'(0));
        @(negedge clk); #1;
        chk("zr_vld", 64'(ifu_vld), 64'(1));
        chk("zr_pc", 64'(ifu_pc), 64'(2));
        chk("zr_ins", 64'(ifu_ins), 64'h00000001);
        // reset in the middle of a pending request, then a stray ack
        waits = 2; #1;
        @(negedge clk); rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; late = 1'b1; #1;
        chk("mr_req", 64'(pmem_req), 64'(0));
        chk("mr_adr", 64'(pmem_adr), 64'(0));
        chk("mr_vld", 64'(ifu_vld), 64'(0));
        chk("mr_ins", 64'(ifu_ins), 64'(0));
        @(negedge clk); late = 1'b0; #1;
        chk("late_adr", 64'(pmem_adr), 64'(0));
        chk("late_vld", 64'(ifu_vld), 64'(0));
        chk("late_req", 64'(pmem_req), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rp_8bit_ifu.md
# rp_8bit_ifu

Instruction fetch unit for the rp_8bit AVR-compatible core. It reads 16-bit words from program memory over a req/ack handshake. It assembles one- and two-word instructions (`lds`, `sts`, `jmp`, `call`) and presents them to decode through a valid/ready output register. It also applies the core's redirect (`jmp_vld`) and skip (`skp`) requests, so discarded and skipped instructions never reach decode.

## Interface
- `PAW`, 22: program address width, in 16-bit words.
- `PC_RST`, 0: reset program counter (word address).

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pmem_req` out 1: program memory read request.
- `pmem_adr` out PAW: word address; held stable while `pmem_req && !pmem_ack`.
- `pmem_rdt` in 16: read data; valid in the `pmem_ack` cycle.
- `pmem_ack` in 1: transfer complete; may be asserted in the same cycle as `pmem_req` (zero wait).
- `ifu_vld` out 1: instruction valid.
- `ifu_rdy` in 1: decode accepts.
- `ifu_ins` out 32: `[15:0]` first word, `[31:16]` second word (0 for one-word instructions).
- `ifu_two` out 1: two-word instruction.
- `ifu_pc` out PAW: word address of the first word.
- `jmp_vld` in 1: redirect; flush and fetch from `jmp_pc`.
- `jmp_pc` in PAW: redirect target.
- `skp` in 1: discard the next instruction (the one currently held, or the next to be assembled).

## Operation
- Two-word detect, applied to the first word: `1001_00?x_xxxx_0000` (lds/sts) or `1001_010x_xxxx_11xx` (jmp/call).
- FSM states:
  - FW (fetch first word): on ack, if two-word, store the word in `ins_lo` and go to SW. Otherwise the instruction is complete.
  - SW (fetch second word): on ack, the instruction is complete; go to FW.
- On instruction complete:
  - If the skip flag is set: clear it and discard the instruction (both words).
  - Otherwise: load the output register and set `ifu_vld`.
- Fetch PC increments by 1 per acked word and wraps modulo 2^PAW (max → 0).
- Request gating: a new `pmem_req` is raised only when the output register is empty or drains this cycle (`ifu_vld && ifu_rdy`). Once raised, `pmem_req` stays high until ack.
- `jmp_vld` (highest priority):
  - Clears `ifu_vld`, `ins_lo` and the skip flag; FSM goes to FW; fetch PC ← `jmp_pc`.
  - If a request is pending without ack, it completes at its held address. Its data is dropped via a drop flag, then fetching resumes at `jmp_pc`.
- `skp`:
  - If `ifu_vld`: the held instruction is discarded.
  - Otherwise: the skip flag is set and the next completed instruction is discarded.
- In a `jmp_vld` or `skp` cycle, `ifu_rdy` is ignored and no decode handshake occurs. If both are asserted, `jmp_vld` wins and `skp` is ignored.
- Outputs `ifu_ins`, `ifu_two`, `ifu_pc` are stable while `ifu_vld && !ifu_rdy`.

## Timing
- Reset values: `pmem_req`=0, `pmem_adr`=`PC_RST`, `ifu_vld`=0, `ifu_ins`=0, `ifu_two`=0, `ifu_pc`=0. FSM = FW, skip and drop flags = 0.
- First `pmem_req` is in the cycle after `rst` deasserts.
- Latency: `ifu_vld` rises one cycle after the ack of the last word of the instruction.
- Throughput with zero-wait memory and `ifu_rdy`=1: one one-word instruction per cycle; a two-word instruction every 2 cycles.
- Redirect: with zero-wait memory, the first request to `jmp_pc` is in the cycle after `jmp_vld`, and its instruction is valid the cycle after that.
- `rst` mid-transaction: all state returns to reset values immediately. A late `pmem_ack` following reset with `pmem_req`=0 is ignored.

## Structure
- Add to the shared package `rp_8bit_pkg`:
  - function `ins_is_two (logic [15:0])`: two-word detect;
  - typedef `ifu_state_t` {FW, SW};
  - constant masks/patterns for lds/sts/jmp/call.
- Single module, no sub-module. The testbench disassembler consumes `ifu_ins`/`ifu_pc` for tracing.

## Test plan
- Reset, zero-wait memory with words `0x0000,0x0000,0x0000`, `ifu_rdy`=1 → `pmem_adr` 0,1,2 on consecutive cycles; `ifu_vld`=1 every cycle from cycle 2; `ifu_pc` 0,1,2.
- Word 0 = `0x940C` (jmp), word 1 = `0x1234` → one output: `ifu_ins`=`0x1234940C`, `ifu_two`=1, `ifu_pc`=0. Next `ifu_pc`=2.
- Output held with `ifu_rdy`=0 for 5 cycles → no new `pmem_req` after the next instruction completes; outputs stable.
- `skp` while `ifu_vld` holds `0x9200` (sts, two-word) at pc 4 → it is never handshaken; the next `ifu_pc`=6.
- `skp` with the output empty, next instruction `0x91C0` (lds) → both words are fetched and discarded; the skip flag clears.
- Memory with 2 wait states, `jmp_vld` with `jmp_pc`=`0x3FFFFF` during a pending request → pending data dropped; the next `ifu_pc`=`0x3FFFFF`, then 0 (wrap).
